// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared types and constants for the systolic tile sequencer.
//               FSM state encoding, default array geometry, and helpers that
//               derive the skew geometry from a given N / BUF_LAT.
// Revision    : 1.0  initial release
// ============================================================================
package systolic_pkg;

    localparam int N_DEF       = 4;
    localparam int BUF_LAT_DEF = 1;

    // Geometry for the default configuration
    localparam int DIAGS      = 2 * N_DEF - 1;
    localparam int SKEW_DEPTH = BUF_LAT_DEF + 2 * N_DEF - 1;
    localparam int DRAIN_LEN  = N_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_SKEW  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic int f_diags(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int f_skew_depth(input int n, input int buf_lat);
        return buf_lat + 2 * n - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_seq_init_skew.sv
`default_nettype none
// ============================================================================
// Module      : init_skew
// Description : Token shift pipe producing the skewed per-anti-diagonal init
//               pulses. Stage 0 is the incoming token itself, stages
//               1..DEPTH-1 are registers; init_diag[d] is tap TAP_LO+d.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_tok           - one token per cycle (feed with k == 0)
//               o_init[TAPS]    - init pulse per anti-diagonal
// Revision    : 1.0  initial release
// ============================================================================
module init_skew #(
    parameter int DEPTH  = 8,
    parameter int TAP_LO = 1,
    parameter int TAPS   = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_tok,
    output logic [TAPS-1:0] o_init
);

    logic [DEPTH-1:0] w_stage;
    logic [DEPTH-1:1] r_sr;

    // Stage 0 is combinational so a token can reach tap 0 in its own cycle
    // when the buffer has no latency.
    assign w_stage = {r_sr, i_tok};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_stage[DEPTH-2:0];
        end
    end

    assign o_init = w_stage[TAP_LO +: TAPS];

endmodule
`default_nettype wire

// File: rtl/systolic_seq.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq
// Description : Tile sequencer for an N x N systolic MAC array. Streams
//               n_tiles x K operand reads, appends one zero flush read,
//               generates skewed per-anti-diagonal init pulses, waits for the
//               last sums to drain and pulses done.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, k_len, n_tiles - launch request and job size
//               busy, done          - job status / completion pulse
//               feed_en, feed_k, feed_tile, feed_zero - operand buffer read
//               init_diag[2N-1]     - init per anti-diagonal
// Revision    : 1.0  initial release
// ============================================================================
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int K_W     = 16,
    parameter int T_W     = 8,
    parameter int BUF_LAT = BUF_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [K_W-1:0]     k_len,
    input  logic [T_W-1:0]     n_tiles,
    output logic               busy,
    output logic               done,
    output logic               feed_en,
    output logic [K_W-1:0]     feed_k,
    output logic [T_W-1:0]     feed_tile,
    output logic               feed_zero,
    output logic [2*N-2:0]     init_diag
);

    localparam int c_diags      = f_diags(N);
    localparam int c_skew_depth = f_skew_depth(N, BUF_LAT);
    // SKEW ends on the cycle the flush token reaches the last diagonal.
    localparam int c_skew_cyc   = BUF_LAT + 2 * N - 2;
    // done lands N+1 cycles after that last init pulse, so DRAIN itself
    // spends N cycles before DONE.
    localparam int c_drain_cyc  = N;
    localparam int c_cnt_max    = (c_skew_cyc > c_drain_cyc) ? c_skew_cyc : c_drain_cyc;
    localparam int c_cnt_w      = $clog2(c_cnt_max + 1);

    state_t              r_state;
    state_t              w_next;
    logic [K_W-1:0]      r_klen;
    logic [T_W-1:0]      r_ntiles;
    logic [K_W-1:0]      r_k;
    logic [T_W-1:0]      r_tile;
    logic [c_cnt_w-1:0]  r_cnt;

    logic w_job_ok;
    logic w_last_k;
    logic w_last_tile;
    logic w_skew_end;
    logic w_drain_end;
    logic w_tok;

    assign w_job_ok    = (k_len != '0) && (n_tiles != '0);
    assign w_last_k    = (r_k == r_klen - K_W'(1));
    assign w_last_tile = (r_tile == r_ntiles - T_W'(1));
    assign w_skew_end  = (r_cnt == c_cnt_w'(c_skew_cyc - 1));
    assign w_drain_end = (r_cnt == c_cnt_w'(c_drain_cyc - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = w_job_ok ? ST_FEED : ST_DONE;
            ST_FEED:  if (w_last_k && w_last_tile) w_next = ST_FLUSH;
            ST_FLUSH: w_next = ST_SKEW;
            ST_SKEW:  if (w_skew_end) w_next = ST_DRAIN;
            ST_DRAIN: if (w_drain_end) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        feed_en   = 1'b0;
        feed_zero = 1'b0;
        feed_k    = '0;
        feed_tile = '0;
        case (r_state)
            ST_FEED: begin
                busy      = 1'b1;
                feed_en   = 1'b1;
                feed_k    = r_k;
                feed_tile = r_tile;
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                feed_en   = 1'b1;
                feed_zero = 1'b1;
                feed_k    = r_k;
                feed_tile = r_tile;
            end
            ST_SKEW, ST_DRAIN: busy = 1'b1;
            ST_DONE:           done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- counters ----------------
    // Nested k/tile counters; the final tile increment leaves r_tile equal
    // to n_tiles for the flush read, which fits T_W for any n_tiles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_klen   <= '0;
            r_ntiles <= '0;
            r_k      <= '0;
            r_tile   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && w_job_ok) begin
                        r_klen   <= k_len;
                        r_ntiles <= n_tiles;
                    end
                    r_k    <= '0;
                    r_tile <= '0;
                    r_cnt  <= '0;
                end
                ST_FEED: begin
                    if (w_last_k) begin
                        r_k    <= '0;
                        r_tile <= r_tile + T_W'(1);
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                ST_SKEW:  r_cnt <= w_skew_end ? '0 : r_cnt + c_cnt_w'(1);
                ST_DRAIN: r_cnt <= r_cnt + c_cnt_w'(1);
                default:  r_cnt <= '0;
            endcase
        end
    end

    assign w_tok = feed_en && (feed_k == '0);

    init_skew #(
        .DEPTH  (c_skew_depth),
        .TAP_LO (BUF_LAT),
        .TAPS   (c_diags)
    ) u_init_skew (
        .clk    (clk),
        .rst    (rst),
        .i_tok  (w_tok),
        .o_init (init_diag)
    );

endmodule
`default_nettype wire
